// File: rtl/axis_spi_arb_pkg.sv
// Shared types and helpers for the SPI master arbiter.
package axis_spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TX    = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // The counter must hold MAX_OUTSTANDING itself, not just MAX_OUTSTANDING-1.
  function automatic int cnt_width(input int max_outstanding);
    return $clog2(max_outstanding) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last_grant,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    int   last;
    logic found;
    gnt   = '0;
    last  = 0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (last_grant[i]) last = i;
    // Offset k=NUM_REQ revisits last_grant itself, so a lone requester is re-granted.
    for (int k = 1; k <= NUM_REQ; k++)
      for (int i = 0; i < NUM_REQ; i++)
        if (!found && req[i] && ((last + k) % NUM_REQ) == i) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
  end

endmodule

// File: rtl/axis_spi_arbiter.sv
// Round-robin sharing of one axis_spi_master between NUM_REQ AXI-Stream requesters.
module axis_spi_arbiter
  import axis_spi_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int DATA_WIDTH      = 8,
  parameter int SLAVE_NUM       = 1,
  parameter int ADDR_WIDTH      = (SLAVE_NUM > 1 ? $clog2(SLAVE_NUM) : 1),
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata_i,
  input  logic [NUM_REQ-1:0]            req_tvalid_i,
  input  logic [NUM_REQ-1:0]            req_tlast_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]            req_tready_o,
  output logic [DATA_WIDTH-1:0]         rsp_tdata_o,
  output logic [NUM_REQ-1:0]            rsp_tvalid_o,
  output logic                          rsp_tlast_o,
  input  logic [NUM_REQ-1:0]            rsp_tready_i,
  output logic [DATA_WIDTH-1:0]         spi_tdata_o,
  output logic                          spi_tvalid_o,
  input  logic                          spi_tready_i,
  output logic [ADDR_WIDTH-1:0]         spi_addr_o,
  input  logic [DATA_WIDTH-1:0]         spi_rx_tdata_i,
  input  logic                          spi_rx_tvalid_i,
  output logic                          spi_rx_tready_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          drop_o
);

  localparam int            CW      = cnt_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  arb_state_t              state;
  logic [NUM_REQ-1:0]      last_grant;
  logic [NUM_REQ-1:0]      pick;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   sel_tdata;
  logic                    sel_tvalid;
  logic                    sel_tlast;
  logic                    sel_rsp_tready;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic                    full;
  logic                    stray;
  logic                    tx_hs;
  logic                    rx_hs;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_tvalid_i),
    .last_grant (last_grant),
    .gnt        (pick)
  );

  always_comb begin
    sel_tdata      = '0;
    sel_tvalid     = 1'b0;
    sel_tlast      = 1'b0;
    sel_rsp_tready = 1'b0;
    pick_addr      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_o[i]) begin
        sel_tdata      = req_tdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tvalid     = req_tvalid_i[i];
        sel_tlast      = req_tlast_i[i];
        sel_rsp_tready = rsp_tready_i[i];
      end
      if (pick[i]) pick_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign full  = (cnt == CNT_MAX);
  // With nothing in flight any RX beat is unsolicited and is swallowed.
  assign stray = (state == IDLE) || (cnt == '0);

  always_comb begin
    spi_tdata_o     = sel_tdata;
    spi_tvalid_o    = (state == TX) && sel_tvalid && !full;
    req_tready_o    = ((state == TX) && spi_tready_i && !full) ? grant_o : '0;
    rsp_tdata_o     = spi_rx_tdata_i;
    rsp_tvalid_o    = (!stray && spi_rx_tvalid_i) ? grant_o : '0;
    spi_rx_tready_o = stray ? 1'b1 : sel_rsp_tready;
    rsp_tlast_o     = (state == DRAIN) && (cnt == CNT_ONE) && spi_rx_tvalid_i;
    busy_o          = (state != IDLE);
  end

  assign tx_hs = spi_tvalid_o && spi_tready_i;
  assign rx_hs = !stray && spi_rx_tvalid_i && sel_rsp_tready;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state      <= IDLE;
      grant_o    <= '0;
      spi_addr_o <= '0;
      cnt        <= '0;
      last_grant <= {1'b1, {(NUM_REQ-1){1'b0}}};
      drop_o     <= 1'b0;
    end else begin
      drop_o <= stray && spi_rx_tvalid_i;
      if (tx_hs && !rx_hs)
        cnt <= cnt + CNT_ONE;
      else if (rx_hs && !tx_hs)
        cnt <= cnt - CNT_ONE;
      case (state)
        IDLE: begin
          if (|req_tvalid_i) begin
            grant_o    <= pick;
            spi_addr_o <= pick_addr;
            state      <= TX;
          end
        end
        TX: begin
          if (tx_hs && sel_tlast) state <= DRAIN;
        end
        DRAIN: begin
          if (cnt == '0) begin
            last_grant <= grant_o;
            grant_o    <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_spi_arbiter.sv
// Bench for axis_spi_arbiter: directed scenarios plus randomized traffic against a packet-level model.
module tb_axis_spi_arbiter;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int AW = 1;
  localparam int MO = 2;

  logic            clk = 1'b0;
  logic            arstn;
  logic [NR*DW-1:0] req_tdata;
  logic [NR-1:0]   req_tvalid, req_tlast, req_tready;
  logic [NR*AW-1:0] req_addr;
  logic [DW-1:0]   rsp_tdata;
  logic [NR-1:0]   rsp_tvalid, rsp_tready;
  logic            rsp_tlast;
  logic [DW-1:0]   spi_tdata;
  logic            spi_tvalid, spi_tready;
  logic [AW-1:0]   spi_addr;
  logic [DW-1:0]   spi_rx_tdata;
  logic            spi_rx_tvalid, spi_rx_tready;
  logic [NR-1:0]   grant;
  logic            busy, drop;

  always #5 clk = ~clk;

  axis_spi_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .SLAVE_NUM(2), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .arstn_i(arstn),
    .req_tdata_i(req_tdata), .req_tvalid_i(req_tvalid), .req_tlast_i(req_tlast),
    .req_addr_i(req_addr), .req_tready_o(req_tready),
    .rsp_tdata_o(rsp_tdata), .rsp_tvalid_o(rsp_tvalid), .rsp_tlast_o(rsp_tlast),
    .rsp_tready_i(rsp_tready),
    .spi_tdata_o(spi_tdata), .spi_tvalid_o(spi_tvalid), .spi_tready_i(spi_tready),
    .spi_addr_o(spi_addr),
    .spi_rx_tdata_i(spi_rx_tdata), .spi_rx_tvalid_i(spi_rx_tvalid), .spi_rx_tready_o(spi_rx_tready),
    .grant_o(grant), .busy_o(busy), .drop_o(drop)
  );

  int checks = 0;
  int failures = 0;

  // requester drivers
  logic [7:0]    txd [NR][$];
  logic          txl [NR][$];
  logic [AW-1:0] txa [NR][$];
  bit            midpk [NR];
  // packet-level reference: grant order, bus stream, per-requester responses
  int            plen [NR][$];
  logic [9:0]    pbyt [NR][$];
  int            exp_own [$];
  logic [9:0]    es [$];
  int            eso [$];
  logic [8:0]    erx [NR][$];
  // slave (SPI master) model: returns tx ^ 8'h5A
  logic [7:0]    rxq [$];
  logic          rxv;
  logic [7:0]    rxd;
  logic [7:0]    pb [$];
  int            outst, mlast;
  int            spi_pct, rsp_pct0, rsp_pct1, gap_pct, rxv_pct;
  logic [NR-1:0] prev_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin
      txd[r].delete(); txl[r].delete(); txa[r].delete();
      plen[r].delete(); pbyt[r].delete(); erx[r].delete();
      midpk[r] = 1'b0;
    end
    exp_own.delete(); es.delete(); eso.delete(); rxq.delete();
    rxv = 1'b0; rxd = '0; outst = 0; mlast = NR - 1; prev_grant = '0;
  endtask

  task automatic add_pkt(input int r, input logic [AW-1:0] a);
    logic l;
    for (int i = 0; i < pb.size(); i++) begin
      l = (i == pb.size() - 1);
      txd[r].push_back(pb[i]); txl[r].push_back(l); txa[r].push_back(a);
      pbyt[r].push_back({a, l, pb[i]});
    end
    plen[r].push_back(pb.size());
    pb.delete();
  endtask

  // Grant order is plain rotation over requesters with packets still queued.
  task automatic plan();
    int pick, c, n;
    logic [9:0] rec;
    forever begin
      pick = -1;
      for (int k = 1; k <= NR; k++) begin
        c = (mlast + k) % NR;
        if (pick < 0 && plen[c].size() > 0) pick = c;
      end
      if (pick < 0) break;
      exp_own.push_back(pick);
      n = plen[pick].pop_front();
      repeat (n) begin
        rec = pbyt[pick].pop_front();
        es.push_back(rec); eso.push_back(pick);
        erx[pick].push_back({rec[8], rec[7:0] ^ 8'h5A});
      end
      mlast = pick;
    end
  endtask

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      if (txd[r].size() > 0) begin
        req_tdata[r*DW +: DW] = txd[r][0];
        req_tlast[r]          = txl[r][0];
        req_addr[r*AW +: AW]  = txa[r][0];
        req_tvalid[r] = !(midpk[r] && $urandom_range(99) < gap_pct);
      end else begin
        req_tvalid[r] = 1'b0;
        req_tlast[r]  = 1'b0;
      end
    end
    spi_tready    = $urandom_range(99) < spi_pct;
    rsp_tready[0] = $urandom_range(99) < rsp_pct0;
    rsp_tready[1] = $urandom_range(99) < rsp_pct1;
    if (!rxv && rxq.size() > 0 && $urandom_range(99) < rxv_pct) begin
      rxv = 1'b1; rxd = rxq[0];
    end
    spi_rx_tvalid = rxv;
    spi_rx_tdata  = rxd;
  endtask

  task automatic sample();
    logic [9:0] rec;
    int o;
    logic txh;
    if (prev_grant == '0 && grant != '0) begin
      if (exp_own.size() == 0) chk("grant_unexpected", grant, 0);
      else chk("grant_order", grant, 32'(1) << exp_own.pop_front());
    end
    prev_grant = grant;
    if (outst >= MO) chk("tx_gated", {spi_tvalid, req_tready}, 0);
    txh = spi_tvalid && spi_tready;
    if (txh) begin
      if (es.size() == 0) chk("tx_unexpected", spi_tdata, 32'hFFFF);
      else begin
        rec = es.pop_front(); o = eso.pop_front();
        chk("tx_beat", {spi_addr, spi_tdata}, {rec[9], rec[7:0]});
        chk("tx_owner", grant, 32'(1) << o);
      end
      rxq.push_back(spi_tdata ^ 8'h5A);
      outst++;
      chk("outst_bound", outst <= MO, 1);
    end
    for (int r = 0; r < NR; r++)
      if (req_tvalid[r] && req_tready[r]) begin
        chk("req_hs_fwd", txh, 1);
        midpk[r] = !txl[r][0];
        void'(txd[r].pop_front()); void'(txl[r].pop_front()); void'(txa[r].pop_front());
      end
    for (int r = 0; r < NR; r++)
      if (rsp_tvalid[r] && rsp_tready[r]) begin
        chk("rsp_onehot", $countones(rsp_tvalid), 1);
        chk("rsp_slave_hs", rxv && spi_rx_tready, 1);
        if (erx[r].size() == 0) chk("rx_unexpected", rsp_tdata, 32'hFFFF);
        else chk("rx_beat", {rsp_tlast, rsp_tdata}, erx[r].pop_front());
        chk("rx_no_drop", drop, 0);
        outst--;
      end
    if (rxv && spi_rx_tready) begin
      void'(rxq.pop_front());
      rxv = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_done(input int limit);
    int n;
    bit pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < limit) begin
      cycle();
      n++;
      pending = (es.size() > 0) || (rxq.size() > 0);
      for (int r = 0; r < NR; r++) if (erx[r].size() > 0) pending = 1'b1;
    end
    repeat (3) cycle();
    chk("done_in_budget", n < limit, 1);
    chk("all_grants_seen", exp_own.size(), 0);
    chk("idle_grant", grant, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic set_rates(input int s, input int r0, input int r1, input int g, input int v);
    spi_pct = s; rsp_pct0 = r0; rsp_pct1 = r1; gap_pct = g; rxv_pct = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, len;
    req_tdata = '0; req_tvalid = '0; req_tlast = '0; req_addr = '0;
    rsp_tready = '0; spi_tready = 1'b0; spi_rx_tdata = '0; spi_rx_tvalid = 1'b0;
    model_clear();
    set_rates(100, 100, 100, 0, 100);
    arstn = 1'b0;
    #12;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", spi_addr, 0);
    chk("rst_spi_tvalid", spi_tvalid, 0);
    chk("rst_req_tready", req_tready, 0);
    chk("rst_rsp_tvalid", rsp_tvalid, 0);
    chk("rst_rsp_tlast", rsp_tlast, 0);
    chk("rst_rx_tready", spi_rx_tready, 1);
    chk("rst_drop", drop, 0);
    @(negedge clk) arstn = 1'b1;
    @(posedge clk); #1; drive();

    // contention from reset: req0 has first priority
    pb.push_back(8'h11); pb.push_back(8'h22); pb.push_back(8'h33); add_pkt(0, 1'b1);
    pb.push_back(8'h44); pb.push_back(8'h55); add_pkt(1, 1'b0);
    plan(); run_done(200);

    // single requester two-byte packet
    pb.push_back(8'hA5); pb.push_back(8'h3C); add_pkt(0, 1'b0);
    plan(); run_done(200);

    // both valid after req0 was last served: req1 goes first
    pb.push_back(8'h01); pb.push_back(8'h02); add_pkt(0, 1'b1);
    pb.push_back(8'h03); pb.push_back(8'h04); add_pkt(1, 1'b1);
    plan(); run_done(200);

    // eight-byte packet with overlapping TX and RX
    for (int i = 0; i < 8; i++) pb.push_back(8'(8'h80 + i));
    add_pkt(0, 1'b0);
    plan(); run_done(300);

    // randomized traffic, including single-beat packets
    set_rates(70, 60, 55, 20, 60);
    for (int p = 0; p < 12; p++) begin
      r = $urandom_range(NR - 1);
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++) pb.push_back(8'($urandom));
      add_pkt(r, AW'($urandom_range(1)));
    end
    plan(); run_done(3000);

    // backpressure: requester 0 not accepting responses
    set_rates(100, 0, 100, 0, 100);
    for (int i = 0; i < 4; i++) pb.push_back(8'(8'hC0 + i));
    add_pkt(0, 1'b1);
    plan();
    repeat (12) cycle();
    #1;
    chk("bp_outst", outst, MO);
    chk("bp_spi_tvalid", spi_tvalid, 0);
    chk("bp_req_tready", req_tready[0], 0);
    chk("bp_busy", busy, 1);
    set_rates(100, 100, 100, 0, 100);
    run_done(200);

    // stray RX beat while idle
    @(posedge clk); #1;
    spi_rx_tvalid = 1'b1; spi_rx_tdata = 8'h77;
    #1;
    chk("stray_rx_tready", spi_rx_tready, 1);
    chk("stray_rsp_tvalid", rsp_tvalid, 0);
    chk("stray_rsp_tlast", rsp_tlast, 0);
    @(posedge clk); #1;
    spi_rx_tvalid = 1'b0;
    chk("stray_drop_pulse", drop, 1);
    chk("stray_busy", busy, 0);
    @(posedge clk); #1;
    chk("stray_drop_end", drop, 0);

    // reset during the second beat of a four-byte packet
    for (int i = 0; i < 4; i++) pb.push_back(8'(8'hD0 + i));
    add_pkt(0, 1'b1);
    plan();
    n = 0;
    while (es.size() > 3 && n < 50) begin cycle(); n++; end
    chk("mid_first_beat", n < 50, 1);
    #2 arstn = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", spi_addr, 0);
    chk("mid_rst_spi_tvalid", spi_tvalid, 0);
    chk("mid_rst_req_tready", req_tready, 0);
    chk("mid_rst_rx_tready", spi_rx_tready, 1);
    model_clear();
    req_tvalid = '0; spi_rx_tvalid = 1'b0;
    @(negedge clk) arstn = 1'b1;
    @(posedge clk); #1; drive();
    pb.push_back(8'hE1); pb.push_back(8'hE2); pb.push_back(8'hE3); add_pkt(1, 1'b1);
    plan(); run_done(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_spi_arbiter.md
Name: axis_spi_arbiter

Overview:
Shares one axis_spi_master between NUM_REQ AXI-Stream requesters. Each requester submits a packet of TX bytes, delimited by tlast, plus a target slave address. The arbiter grants requesters round-robin, drives the master's addr_i and s_axis, and routes the master's m_axis RX bytes back to the granted requester. The grant holds until every RX byte of the packet has returned (SPI full duplex: one RX beat per TX beat).

Parameters:
NUM_REQ, 2, number of requesters (≥2)
DATA_WIDTH, 8, SPI word width
SLAVE_NUM, 1, number of chip selects on the master
ADDR_WIDTH, (SLAVE_NUM>1 ? $clog2(SLAVE_NUM) : 1), slave address width
MAX_OUTSTANDING, 16, max TX beats in flight without a returned RX beat (power of 2)

Ports:
clk_i  in  1  system clock
arstn_i  in  1  asynchronous active-low reset
req_tdata_i  in  NUM_REQ*DATA_WIDTH  per-requester TX data, requester i at slice i
req_tvalid_i  in  NUM_REQ  per-requester TX valid
req_tlast_i  in  NUM_REQ  per-requester end of packet
req_addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester slave address, sampled at grant
req_tready_o  out  NUM_REQ  per-requester TX ready
rsp_tdata_o  out  DATA_WIDTH  RX data, broadcast to all requesters
rsp_tvalid_o  out  NUM_REQ  RX valid, only the granted bit may be high
rsp_tlast_o  out  1  last RX beat of the packet
rsp_tready_i  in  NUM_REQ  per-requester RX ready
spi_tdata_o  out  DATA_WIDTH  to master s_axis.tdata
spi_tvalid_o  out  1  to master s_axis.tvalid
spi_tready_i  in  1  from master s_axis.tready
spi_addr_o  out  ADDR_WIDTH  to master addr_i
spi_rx_tdata_i  in  DATA_WIDTH  from master m_axis.tdata
spi_rx_tvalid_i  in  1  from master m_axis.tvalid
spi_rx_tready_o  out  1  to master m_axis.tready
grant_o  out  NUM_REQ  one-hot current grant, 0 when idle
busy_o  out  1  high in any state other than IDLE
drop_o  out  1  one-cycle pulse when a stray RX beat is discarded

Behaviour:
- Reset values (async on arstn_i low): state=IDLE, grant_o=0, spi_addr_o=0, outstanding counter=0, last_grant=NUM_REQ-1 so requester 0 has first priority. All valid/ready outputs are 0, except spi_rx_tready_o, which is 1 in IDLE. busy_o=0, drop_o=0, rsp_tlast_o=0. Reset mid-packet abandons the packet and outstanding RX beats.
- States: IDLE, TX, DRAIN.
- IDLE:
  - If any req_tvalid_i bit is set, choose the first valid requester searching from last_grant+1, wrapping modulo NUM_REQ.
  - Register grant_o and spi_addr_o from that requester's address, then go to TX.
  - Arbitration latency is one cycle: the first TX beat can hand off no earlier than the cycle after the request is seen.
  - No req_tready_o asserted in IDLE.
- TX:
  - Combinational pass-through: spi_tdata_o and spi_tvalid_o take the granted requester's signals; req_tready_o[g] = spi_tready_i. Other ready bits stay 0.
  - Gating: when the counter equals MAX_OUTSTANDING, spi_tvalid_o and req_tready_o[g] are forced to 0.
  - A TX handshake with tlast goes to DRAIN.
- DRAIN: no TX forwarding. Exit to IDLE in the cycle after the counter reaches 0, and update last_grant to g on exit.
- RX path in TX and DRAIN:
  - rsp_tvalid_o[g] = spi_rx_tvalid_i and spi_rx_tready_o = rsp_tready_i[g], with rsp_tdata_o = spi_rx_tdata_i.
  - rsp_tlast_o = (state==DRAIN && counter==1 && spi_rx_tvalid_i).
- Outstanding counter (width $clog2(MAX_OUTSTANDING)+1):
  - +1 on a TX handshake, -1 on an RX handshake.
  - Simultaneous TX and RX handshakes leave it unchanged.
  - Never underflows: an RX beat arriving while the counter is 0 is a stray.
- Stray RX beats (IDLE, or counter==0): accept with spi_rx_tready_o=1, discard the data, and pulse drop_o.
- spi_addr_o is stable for the whole grant; the master's CS is therefore never retargeted mid-packet.
- Single-beat packet (tvalid and tlast on the first beat): TX→DRAIN after one beat, and rsp_tlast_o is set on the single RX beat.
- Requests that drop tvalid while not granted are legal; no request is latched.

Decomposition:
- Package axis_spi_arb_pkg holds the state enum (IDLE, TX, DRAIN) and a cnt_width function.
- Sub-module rr_arbiter (parameter NUM_REQ) is a combinational round-robin pick: inputs req and last_grant (one-hot), output one-hot gnt. It is reusable elsewhere.
- The FSM, counter and muxing stay in axis_spi_arbiter.

Test Plan:
- Single requester: req0 sends 0xA5,0x3C (tlast), addr 0 → spi_tdata sequence A5,3C. Slave echo returns two beats on rsp with tvalid[0] only, tlast on the 2nd. grant_o=01 throughout, then 00; busy_o falls after drain.
- Contention: req0 and req1 both valid in the same IDLE cycle from reset → req0 served first (3 bytes), then req1. Next round with both valid → req1 is served before req0.
- Simultaneous handshakes: hold rsp_tready high with 8-byte packets so TX and RX overlap → counter never exceeds 2 with the SPI master. All 8 RX beats are delivered in order, and tlast is only on the 8th.
- Backpressure: MAX_OUTSTANDING=2, rsp_tready[0]=0 → after 2 TX beats spi_tvalid_o=0 and req_tready_o[0]=0. Releasing rsp_tready resumes TX, and no bytes are lost.
- Stray beat: force spi_rx_tvalid_i in IDLE with data 0x77 → accepted, drop_o pulses once, rsp_tvalid_o stays 0.
- Reset mid-packet: assert arstn_i low during the 2nd beat of a 4-byte packet → all outputs take reset values immediately. After release, a new req1 packet is granted normally.
